controlador_zoom: RTL

CONTROLADOR_ZOOM -- requirements
Module: controlador_zoom

---
 rtl/controlador_zoom.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/controlador_zoom.sv
// Zoom controller: walks the destination raster, reads the mapped source pixel
// and writes it to the destination memory at 1x, 2x or 4x scale.
module controlador_zoom #(
  parameter int unsigned LARGURA_FONTE = 160,
  parameter int unsigned ALTURA_FONTE  = 120,
  parameter int unsigned LARGURA_PIXEL = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     iniciar,
  input  logic [1:0]               fator_zoom,
  output logic [9:0]               x_destino,
  output logic [9:0]               y_destino,
  input  logic [9:0]               x_fonte,
  input  logic [9:0]               y_fonte,
  output logic                     leitura_en,
  output logic [14:0]              end_leitura,
  input  logic [LARGURA_PIXEL-1:0] dado_leitura,
  output logic                     escrita_valida,
  input  logic                     escrita_pronta,
  output logic [18:0]              end_escrita,
  output logic [LARGURA_PIXEL-1:0] dado_escrita,
  output logic                     ocupado,
  output logic                     concluido
);

  localparam int unsigned LARG_COORD    = 10;
  localparam int unsigned LARG_END_LEIT = 15;
  localparam int unsigned LARG_END_ESC  = 19;

  typedef enum logic [2:0] {OCIOSO, LER, ESPERA, ESCREVE, CONCLUIDO} estado_t;

  estado_t                   estado_q, estado_d;
  logic [1:0]                s_q, s_d;
  logic [LARG_COORD-1:0]     x_q, x_d, y_q, y_d;
  logic                      ultimo_q, ultimo_d;
  logic                      leitura_en_q, leitura_en_d;
  logic [LARG_END_LEIT-1:0]  end_leitura_q, end_leitura_d;
  logic                      escrita_valida_q, escrita_valida_d;
  logic [LARG_END_ESC-1:0]   end_escrita_q, end_escrita_d;
  logic [LARGURA_PIXEL-1:0]  dado_escrita_q, dado_escrita_d;
  logic                      ocupado_q, ocupado_d;
  logic                      concluido_q, concluido_d;

  int unsigned larg_dest, alt_dest, end_leitura_calc, end_escrita_calc;
  logic        fim_linha, fim_coluna;

  assign larg_dest        = LARGURA_FONTE << s_q;
  assign alt_dest         = ALTURA_FONTE << s_q;
  assign fim_linha        = (32'(x_q) == larg_dest - 1);
  assign fim_coluna       = (32'(y_q) == alt_dest - 1);
  assign end_leitura_calc = 32'(y_fonte) * LARGURA_FONTE + 32'(x_fonte);
  assign end_escrita_calc = 32'(y_q) * larg_dest + 32'(x_q);

  // Counters advance when the write address is captured, so the mapper already
  // presents the next pixel when the read address is registered on entry to LER.
  always_comb begin
    estado_d       = estado_q;
    s_d            = s_q;
    x_d            = x_q;
    y_d            = y_q;
    ultimo_d       = ultimo_q;
    end_leitura_d  = end_leitura_q;
    end_escrita_d  = end_escrita_q;
    dado_escrita_d = dado_escrita_q;

    case (estado_q)
      OCIOSO: begin
        if (iniciar) begin
          case (fator_zoom)
            2'b01:   s_d = 2'd1;
            2'b10:   s_d = 2'd2;
            default: s_d = 2'd0;
          endcase
          x_d      = '0;
          y_d      = '0;
          estado_d = LER;
        end
      end
      LER: estado_d = ESPERA;
      ESPERA: begin
        dado_escrita_d = dado_leitura;
        end_escrita_d  = LARG_END_ESC'(end_escrita_calc);
        ultimo_d       = fim_linha && fim_coluna;
        if (fim_linha) begin
          x_d = '0;
          y_d = fim_coluna ? '0 : y_q + LARG_COORD'(1);
        end else begin
          x_d = x_q + LARG_COORD'(1);
        end
        estado_d = ESCREVE;
      end
      ESCREVE: begin
        if (escrita_pronta) estado_d = ultimo_q ? CONCLUIDO : LER;
      end
      CONCLUIDO: begin
        x_d      = '0;
        y_d      = '0;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase

    if (estado_d == LER && estado_q != LER) end_leitura_d = LARG_END_LEIT'(end_leitura_calc);

    // Strobes are decoded from the next state so they are registered yet aligned with it.
    leitura_en_d     = (estado_d == LER);
    escrita_valida_d = (estado_d == ESCREVE);
    ocupado_d        = (estado_d == LER) || (estado_d == ESPERA) || (estado_d == ESCREVE);
    concluido_d      = (estado_d == CONCLUIDO);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q         <= OCIOSO;
      s_q              <= '0;
      x_q              <= '0;
      y_q              <= '0;
      ultimo_q         <= 1'b0;
      leitura_en_q     <= 1'b0;
      end_leitura_q    <= '0;
      escrita_valida_q <= 1'b0;
      end_escrita_q    <= '0;
      dado_escrita_q   <= '0;
      ocupado_q        <= 1'b0;
      concluido_q      <= 1'b0;
    end else begin
      estado_q         <= estado_d;
      s_q              <= s_d;
      x_q              <= x_d;
      y_q              <= y_d;
      ultimo_q         <= ultimo_d;
      leitura_en_q     <= leitura_en_d;
      end_leitura_q    <= end_leitura_d;
      escrita_valida_q <= escrita_valida_d;
      end_escrita_q    <= end_escrita_d;
      dado_escrita_q   <= dado_escrita_d;
      ocupado_q        <= ocupado_d;
      concluido_q      <= concluido_d;
    end
  end

  assign x_destino      = x_q;
  assign y_destino      = y_q;
  assign leitura_en     = leitura_en_q;
  assign end_leitura    = end_leitura_q;
  assign escrita_valida = escrita_valida_q;
  assign end_escrita    = end_escrita_q;
  assign dado_escrita   = dado_escrita_q;
  assign ocupado        = ocupado_q;
  assign concluido      = concluido_q;

endmodule
